// File: rtl/spi_bus_arbiter_pkg.sv
// Shared encodings for the SPI bus arbiter: FSM states, port identities
// and the owner code reported on the status output.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } arb_port_t;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_A    = 2'b01;
   localparam logic [1:0] OWNER_B    = 2'b10;
   localparam logic [1:0] OWNER_GAP  = 2'b11;

   // Translate an FSM state into the externally visible owner code.
   function automatic logic [1:0] owner_code(arb_state_t st);
      logic [1:0] code;
      case (st)
         ST_OWN_A: code = OWNER_A;
         ST_OWN_B: code = OWNER_B;
         ST_GAP:   code = OWNER_GAP;
         default:  code = OWNER_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Bundle of the two masters' request/SPI lines, the shared bus lines and
// the arbiter status. The arbiter connects through the slave modport;
// whatever drives the requests connects through the master modport.
interface spi_bus_arbiter_if;

   logic       a_req;
   logic       a_grant;
   logic       a_sel_n;
   logic       a_mosi;
   logic       a_clk_en;

   logic       b_req;
   logic       b_grant;
   logic       b_sel_n;
   logic       b_mosi;
   logic       b_clk_en;

   logic       bus_sel_n;
   logic       bus_mosi;
   logic       bus_clk_en;
   logic [1:0] owner;
   logic       proto_err;

   modport slave (
      input  a_req, a_sel_n, a_mosi, a_clk_en,
      input  b_req, b_sel_n, b_mosi, b_clk_en,
      output a_grant, b_grant,
      output bus_sel_n, bus_mosi, bus_clk_en, owner, proto_err
   );

   modport master (
      output a_req, a_sel_n, a_mosi, a_clk_en,
      output b_req, b_sel_n, b_mosi, b_clk_en,
      input  a_grant, b_grant,
      input  bus_sel_n, bus_mosi, bus_clk_en, owner, proto_err
   );

endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-master SPI bus arbiter. Ownership only moves between frames and a
// guaranteed chip-select-high gap (GAP state plus one IDLE cycle)
// separates frames of successive owners. Frames are never cut short: an
// owner that drops its request mid-frame keeps the bus until sel_n rises,
// and the protocol error is latched until reset.
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int GAP_CYCLES   = 2,
   parameter bit FIXED_PRIO_B = 1'b0
) (
   input  logic                cpu_clk,
   input  logic                rstn,
   spi_bus_arbiter_if.slave    bus_if
);

   localparam int              CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

   arb_state_t       state_q, state_d;
   arb_port_t        last_owner_q, last_owner_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             proto_err_q, proto_err_d;
   logic             a_grant_q, a_grant_d;
   logic             b_grant_q, b_grant_d;
   logic [1:0]       owner_q, owner_d;

   // Next-state logic: arbitration in IDLE, release detection while owned,
   // and the gap countdown that enforces the chip-select-high interval.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      gap_cnt_d    = gap_cnt_q;
      proto_err_d  = proto_err_q;

      case (state_q)
         ST_IDLE: begin
            if (bus_if.a_req && bus_if.b_req) begin
               if (FIXED_PRIO_B || (last_owner_q == PORT_A)) begin
                  state_d      = ST_OWN_B;
                  last_owner_d = PORT_B;
               end else begin
                  state_d      = ST_OWN_A;
                  last_owner_d = PORT_A;
               end
            end else if (bus_if.a_req) begin
               state_d      = ST_OWN_A;
               last_owner_d = PORT_A;
            end else if (bus_if.b_req) begin
               state_d      = ST_OWN_B;
               last_owner_d = PORT_B;
            end
         end
         ST_OWN_A: begin
            if (!bus_if.a_req) begin
               if (bus_if.a_sel_n) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
               end else begin
                  proto_err_d = 1'b1;
               end
            end
         end
         ST_OWN_B: begin
            if (!bus_if.b_req) begin
               if (bus_if.b_sel_n) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
               end else begin
                  proto_err_d = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      a_grant_d = (state_d == ST_OWN_A);
      b_grant_d = (state_d == ST_OWN_B);
      owner_d   = owner_code(state_d);
   end

   // State and registered status outputs, with synchronous active-low reset.
   always_ff @(posedge cpu_clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         last_owner_q <= PORT_A;
         gap_cnt_q    <= '0;
         proto_err_q  <= 1'b0;
         a_grant_q    <= 1'b0;
         b_grant_q    <= 1'b0;
         owner_q      <= OWNER_NONE;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         gap_cnt_q    <= gap_cnt_d;
         proto_err_q  <= proto_err_d;
         a_grant_q    <= a_grant_d;
         b_grant_q    <= b_grant_d;
         owner_q      <= owner_d;
      end
   end

   // Bus mux: only the registered owner reaches the pads; otherwise idle levels.
   always_comb begin
      bus_if.bus_sel_n  = 1'b1;
      bus_if.bus_mosi   = 1'b0;
      bus_if.bus_clk_en = 1'b0;
      case (state_q)
         ST_OWN_A: begin
            bus_if.bus_sel_n  = bus_if.a_sel_n;
            bus_if.bus_mosi   = bus_if.a_mosi;
            bus_if.bus_clk_en = bus_if.a_clk_en;
         end
         ST_OWN_B: begin
            bus_if.bus_sel_n  = bus_if.b_sel_n;
            bus_if.bus_mosi   = bus_if.b_mosi;
            bus_if.bus_clk_en = bus_if.b_clk_en;
         end
         default: ;
      endcase
   end

   assign bus_if.a_grant   = a_grant_q;
   assign bus_if.b_grant   = b_grant_q;
   assign bus_if.owner     = owner_q;
   assign bus_if.proto_err = proto_err_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Testbench for spi_bus_arbiter. Two instances (round-robin and fixed
// priority B) share the same master stimulus; each is compared every cycle
// against a per-instance reference model that tracks who holds the bus and
// how long the bus has been free since the last release.
module tb_spi_bus_arbiter;
   import spi_arb_pkg::*;

   localparam int GAP = 2;

   logic cpu_clk = 1'b0;
   logic rstn    = 1'b0;
   logic a_req = 1'b0, a_sel_n = 1'b1, a_mosi = 1'b0, a_clk_en = 1'b0;
   logic b_req = 1'b0, b_sel_n = 1'b1, b_mosi = 1'b0, b_clk_en = 1'b0;

   int checks = 0;
   int errors = 0;

   // Model: holder 0=nobody 1=A 2=B; quiet = cycles since last release.
   int m_holder[2];
   int m_quiet[2];
   int m_last[2];
   bit m_perr[2];
   bit m_prio_b[2];

   logic [39:0] frame;

   always #5 cpu_clk = ~cpu_clk;

   spi_bus_arbiter_if if_rr ();
   spi_bus_arbiter_if if_fp ();

   assign if_rr.a_req = a_req;  assign if_rr.a_sel_n = a_sel_n;
   assign if_rr.a_mosi = a_mosi; assign if_rr.a_clk_en = a_clk_en;
   assign if_rr.b_req = b_req;  assign if_rr.b_sel_n = b_sel_n;
   assign if_rr.b_mosi = b_mosi; assign if_rr.b_clk_en = b_clk_en;
   assign if_fp.a_req = a_req;  assign if_fp.a_sel_n = a_sel_n;
   assign if_fp.a_mosi = a_mosi; assign if_fp.a_clk_en = a_clk_en;
   assign if_fp.b_req = b_req;  assign if_fp.b_sel_n = b_sel_n;
   assign if_fp.b_mosi = b_mosi; assign if_fp.b_clk_en = b_clk_en;

   spi_bus_arbiter #(.GAP_CYCLES(GAP), .FIXED_PRIO_B(1'b0)) dut_rr (
      .cpu_clk (cpu_clk),
      .rstn    (rstn),
      .bus_if  (if_rr)
   );

   spi_bus_arbiter #(.GAP_CYCLES(GAP), .FIXED_PRIO_B(1'b1)) dut_fp (
      .cpu_clk (cpu_clk),
      .rstn    (rstn),
      .bus_if  (if_fp)
   );

   task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
      end
   endtask

   // Advance the reference model by one clock using the inputs seen at the edge.
   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         if (!rstn) begin
            m_holder[d] = 0;
            m_quiet[d]  = GAP;
            m_last[d]   = 1;
            m_perr[d]   = 1'b0;
         end else if (m_holder[d] != 0) begin
            logic req, sel;
            req = (m_holder[d] == 1) ? a_req : b_req;
            sel = (m_holder[d] == 1) ? a_sel_n : b_sel_n;
            if (!req && !sel) begin
               m_perr[d] = 1'b1;
            end else if (!req) begin
               m_holder[d] = 0;
               m_quiet[d]  = 0;
            end
         end else if (m_quiet[d] < GAP) begin
            m_quiet[d]++;
         end else if (a_req || b_req) begin
            int w;
            if (a_req && b_req) w = (m_prio_b[d] || m_last[d] == 1) ? 2 : 1;
            else                w = a_req ? 1 : 2;
            m_holder[d] = w;
            m_last[d]   = w;
         end
      end
   endtask

   task automatic check_dut(input int d, input string nm,
                            input logic ag, input logic bg, input logic [1:0] own,
                            input logic sel, input logic mosi, input logic ce, input logic perr);
      logic [1:0] e_own;
      logic e_sel, e_mosi, e_ce;
      if (m_holder[d] == 1) begin
         e_own = 2'b01; e_sel = a_sel_n; e_mosi = a_mosi; e_ce = a_clk_en;
      end else if (m_holder[d] == 2) begin
         e_own = 2'b10; e_sel = b_sel_n; e_mosi = b_mosi; e_ce = b_clk_en;
      end else begin
         e_own = (m_quiet[d] < GAP) ? 2'b11 : 2'b00;
         e_sel = 1'b1; e_mosi = 1'b0; e_ce = 1'b0;
      end
      checkOutput({nm, ".a_grant"},    {1'b0, ag},   {1'b0, m_holder[d] == 1});
      checkOutput({nm, ".b_grant"},    {1'b0, bg},   {1'b0, m_holder[d] == 2});
      checkOutput({nm, ".owner"},      own,          e_own);
      checkOutput({nm, ".bus_sel_n"},  {1'b0, sel},  {1'b0, e_sel});
      checkOutput({nm, ".bus_mosi"},   {1'b0, mosi}, {1'b0, e_mosi});
      checkOutput({nm, ".bus_clk_en"}, {1'b0, ce},   {1'b0, e_ce});
      checkOutput({nm, ".proto_err"},  {1'b0, perr}, {1'b0, m_perr[d]});
   endtask

   // Drive both masters, clock once, then compare both instances to the model.
   task automatic applyStimulus(input logic ar, input logic asel, input logic amosi, input logic ace,
                                input logic br, input logic bsel, input logic bmosi, input logic bce);
      a_req = ar; a_sel_n = asel; a_mosi = amosi; a_clk_en = ace;
      b_req = br; b_sel_n = bsel; b_mosi = bmosi; b_clk_en = bce;
      @(posedge cpu_clk);
      model_update();
      @(negedge cpu_clk);
      check_dut(0, "rr", if_rr.a_grant, if_rr.b_grant, if_rr.owner, if_rr.bus_sel_n,
                if_rr.bus_mosi, if_rr.bus_clk_en, if_rr.proto_err);
      check_dut(1, "fp", if_fp.a_grant, if_fp.b_grant, if_fp.owner, if_fp.bus_sel_n,
                if_fp.bus_mosi, if_fp.bus_clk_en, if_fp.proto_err);
   endtask

   task automatic idle_cycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      m_prio_b[0] = 1'b0;
      m_prio_b[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_holder[d] = 0; m_quiet[d] = GAP; m_last[d] = 1; m_perr[d] = 1'b0;
      end

      $display("[TB] reset");
      rstn = 1'b0;
      idle_cycle();
      idle_cycle();
      rstn = 1'b1;
      checkOutput("reset.owner", if_rr.owner, OWNER_NONE);
      checkOutput("reset.bus_sel_n", {1'b0, if_rr.bus_sel_n}, 2'b01);

      $display("[TB] port A alone, 40-bit frame");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("a_only.a_grant", {1'b0, if_rr.a_grant}, 2'b01);
      checkOutput("a_only.owner", if_rr.owner, OWNER_A);
      frame = 40'({$urandom(), $urandom()});
      for (int i = 39; i >= 0; i--) begin
         applyStimulus(1'b1, 1'b0, frame[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         checkOutput("frame.mosi", {1'b0, if_rr.bus_mosi}, {1'b0, frame[i]});
         checkOutput("frame.sel_n", {1'b0, if_rr.bus_sel_n}, 2'b00);
      end
      idle_cycle();
      checkOutput("release.owner0", if_rr.owner, OWNER_GAP);
      idle_cycle();
      checkOutput("release.owner1", if_rr.owner, OWNER_GAP);
      idle_cycle();
      checkOutput("release.idle", if_rr.owner, OWNER_NONE);

      $display("[TB] both request after reset");
      rstn = 1'b0;
      idle_cycle();
      rstn = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("both.rr_b_first", {1'b0, if_rr.b_grant}, 2'b01);
      checkOutput("both.fp_b_first", {1'b0, if_fp.b_grant}, 2'b01);
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom_range(1)), 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("handover.gap0", if_rr.owner, OWNER_GAP);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("handover.gap1", if_rr.owner, OWNER_GAP);
      checkOutput("handover.sel_high", {1'b0, if_rr.bus_sel_n}, 2'b01);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("handover.idle", if_rr.owner, OWNER_NONE);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("handover.a_grant", {1'b0, if_rr.a_grant}, 2'b01);

      $display("[TB] repeated re-request rounds");
      for (int r = 0; r < 4; r++) begin
         idle_cycle();
         for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         checkOutput("round.fp_owner", if_fp.owner, OWNER_B);
         checkOutput("round.rr_owner", if_rr.owner, (r % 2 == 0) ? OWNER_B : OWNER_A);
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++)
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("fp.a_after_b_drops", {1'b0, if_fp.a_grant}, 2'b01);

      $display("[TB] request dropped mid-frame");
      rstn = 1'b0;
      idle_cycle();
      rstn = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'(k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         checkOutput("perr.set", {1'b0, if_rr.proto_err}, 2'b01);
         checkOutput("perr.still_owned", if_rr.owner, OWNER_A);
         checkOutput("perr.sel_low", {1'b0, if_rr.bus_sel_n}, 2'b00);
      end
      idle_cycle();
      checkOutput("perr.gap", if_rr.owner, OWNER_GAP);
      for (int k = 0; k < 3; k++) idle_cycle();
      checkOutput("perr.sticky", {1'b0, if_rr.proto_err}, 2'b01);

      $display("[TB] B noise while A owns");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                       1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
         checkOutput("noise.b_grant", {1'b0, if_rr.b_grant}, 2'b00);
         checkOutput("noise.sel_tracks_a", {1'b0, if_rr.bus_sel_n}, {1'b0, a_sel_n});
      end

      $display("[TB] reset mid-frame");
      rstn = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      rstn = 1'b1;
      checkOutput("midrst.owner", if_rr.owner, OWNER_NONE);
      checkOutput("midrst.a_grant", {1'b0, if_rr.a_grant}, 2'b00);
      checkOutput("midrst.sel_n", {1'b0, if_rr.bus_sel_n}, 2'b01);
      checkOutput("midrst.perr", {1'b0, if_rr.proto_err}, 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("midrst.rr_b_wins", {1'b0, if_rr.b_grant}, 2'b01);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 1500; n++) begin
         logic ar, asel, br, bsel;
         ar   = a_req   ^ ($urandom_range(7) == 0);
         asel = a_sel_n ^ ($urandom_range(2) == 0);
         br   = b_req   ^ ($urandom_range(7) == 0);
         bsel = b_sel_n ^ ($urandom_range(2) == 0);
         rstn = ($urandom_range(149) != 0);
         applyStimulus(ar, asel, 1'($urandom_range(1)), 1'($urandom_range(1)),
                       br, bsel, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      rstn = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
